// File: rtl/draw_pkg.sv
// draw_pkg: definitions shared by every draw engine in the game.
//   SCREEN_W/SCREEN_H : visible VGA-adapter area in pixels
//   COLOUR_W          : adapter colour depth
//   X_W/Y_W           : adapter coordinate widths
//   draw_state_t      : common engine state encoding (IDLE, RUN, DRAIN, DONE)
//   cnt_width()       : counter width able to index 0..n-1, never narrower than 1 bit
package draw_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } draw_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_raster_counter.sv
// image_raster_counter: column/row raster counters for an IMG_W x IMG_H image.
//   clock_all  in   system clock
//   reset_all  in   asynchronous active-low reset
//   clear      in   return to pixel 0 (takes priority over enable)
//   enable     in   advance one pixel, column innermost
//   col        out  current column
//   row        out  current row
//   row_base   out  row*IMG_W, kept as a running sum so no multiplier is needed
//   last       out  current position is the final pixel of the image
module image_raster_counter
  import draw_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic                        clock_all,
  input  logic                        reset_all,
  input  logic                        clear,
  input  logic                        enable,
  output logic [cnt_width(IMG_W)-1:0] col,
  output logic [cnt_width(IMG_H)-1:0] row,
  output logic [ADDR_W-1:0]           row_base,
  output logic                        last
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  logic col_last;
  logic row_last;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign last     = col_last && row_last;

  // The whole raster wraps back to pixel 0 after the last pixel, so a
  // following draw needs no extra clear even if one were skipped.
  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (clear) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (enable) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row      <= '0;
          row_base <= '0;
        end else begin
          row      <= row + 1'b1;
          row_base <= row_base + ROW_STEP;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_image_engine.sv
// draw_image_engine: blits an IMG_W x IMG_H image from an external synchronous
// ROM to the VGA adapter at (base_x+col, base_y+row), one pixel per cycle.
//   clock_all  in   system clock
//   reset_all  in   asynchronous active-low reset
//   start      in   draw request, honoured only in IDLE
//   base_x/y   in   top-left screen position, latched on accepted start
//   flip_x     in   horizontal mirror, latched on accepted start
//   rom_addr   out  image ROM address (data returns on rom_q one cycle later)
//   rom_q      in   image ROM colour
//   out_x/y    out  adapter pixel position
//   out_colour out  adapter colour (rom_q passed straight through)
//   plot       out  adapter write enable
//   busy       out  high while pixels are being issued or drained
//   done       out  single-cycle completion pulse
module draw_image_engine
  import draw_pkg::*;
#(
  parameter int                  IMG_W      = 320,
  parameter int                  IMG_H      = 240,
  parameter int                  ADDR_W     = 17,
  parameter bit                  TRANSP_EN  = 1'b0,
  parameter logic [COLOUR_W-1:0] TRANSP_COL = 3'b000
) (
  input  logic                clock_all,
  input  logic                reset_all,
  input  logic                start,
  input  logic [X_W-1:0]      base_x,
  input  logic [Y_W-1:0]      base_y,
  input  logic                flip_x,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [X_W-1:0]      out_x,
  output logic [Y_W-1:0]      out_y,
  output logic [COLOUR_W-1:0] out_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);
  // Sums are one bit wider than either operand so an image hanging off the
  // right/bottom edge is clipped rather than wrapped onto the left/top.
  localparam int XS_W = ((COL_W > X_W) ? COL_W : X_W) + 1;
  localparam int YS_W = ((ROW_W > Y_W) ? ROW_W : Y_W) + 1;
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_W - 1);

  draw_state_t        state;
  draw_state_t        state_next;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [ADDR_W-1:0]  row_base;
  logic               last_pixel;
  logic [X_W-1:0]     base_x_q;
  logic [Y_W-1:0]     base_y_q;
  logic               flip_q;
  logic               accept;
  logic               running;
  logic [XS_W-1:0]    x_sum;
  logic [YS_W-1:0]    y_sum;
  logic               pipe_valid;
  logic               pipe_on_screen;
  logic               transparent;

  assign accept  = (state == IDLE) && start;
  assign running = (state == RUN);

  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DRAIN lets the last pixel's ROM data arrive; DONE is the completion pulse
  // and deliberately ignores start, so a held start cannot chain draws early.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_pixel) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Position and mirroring are frozen for the whole draw.
  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      base_x_q <= '0;
      base_y_q <= '0;
      flip_q   <= 1'b0;
    end else if (accept) begin
      base_x_q <= base_x;
      base_y_q <= base_y;
      flip_q   <= flip_x;
    end
  end

  image_raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clock_all (clock_all),
    .reset_all (reset_all),
    .clear     (!running),
    .enable    (running),
    .col       (col),
    .row       (row),
    .row_base  (row_base),
    .last      (last_pixel)
  );

  // Mirroring only changes which ROM word is fetched; the screen column
  // still advances left to right.
  assign rom_addr = row_base + (flip_q ? (COL_MAX - ADDR_W'(col)) : ADDR_W'(col));

  assign x_sum = XS_W'(base_x_q) + XS_W'(col);
  assign y_sum = YS_W'(base_y_q) + YS_W'(row);

  // Position and visibility are delayed one stage to line up with rom_q.
  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      pipe_valid     <= 1'b0;
      pipe_on_screen <= 1'b0;
      out_x          <= '0;
      out_y          <= '0;
    end else begin
      pipe_valid     <= running;
      pipe_on_screen <= (x_sum < XS_W'(SCREEN_W)) && (y_sum < YS_W'(SCREEN_H));
      out_x          <= x_sum[X_W-1:0];
      out_y          <= y_sum[Y_W-1:0];
    end
  end

  assign transparent = TRANSP_EN && (rom_q == TRANSP_COL);
  assign plot        = pipe_valid && pipe_on_screen && !transparent;
  assign out_colour  = rom_q;
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

endmodule
